// File: rtl/rect_grid_pkg.sv
// Shared definitions for the snake play field: grid geometry, cell codes,
// rectangle-interface field positions and the grid memory FSM encoding.
package rect_grid_pkg;

  localparam int GRID_SIZE_X = 32;
  localparam int GRID_SIZE_Y = 24;
  localparam int CELL_W      = 4;

  // Index is {y, x}; x uses exactly log2(GRID_SIZE_X) bits, y needs 5 bits for 24 rows
  localparam int X_BITS   = $clog2(GRID_SIZE_X);
  localparam int Y_BITS   = $clog2(GRID_SIZE_Y);
  localparam int IDX_W    = X_BITS + Y_BITS;
  localparam int CELL_NUM = GRID_SIZE_X * GRID_SIZE_Y;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELL_NUM - 1);

  typedef logic [CELL_W-1:0] cell_t;

  localparam cell_t CELL_NULL  = 4'b0000;
  localparam cell_t CELL_SNAKE = 4'b0001;
  localparam cell_t CELL_ROCK  = 4'b0010;
  localparam cell_t CELL_SNACK = 4'b0100;

  // rect_write = {x[35:20], y[19:4], func[3:0]}
  localparam int WR_W     = 36;
  localparam int WR_X_MSB = 35;
  localparam int WR_X_LSB = 20;
  localparam int WR_Y_MSB = 19;
  localparam int WR_Y_LSB = 4;
  localparam int WR_F_MSB = 3;
  localparam int WR_F_LSB = 0;

  // rect_read_addr = {x[31:16], y[15:0]}
  localparam int RD_W     = 32;
  localparam int RD_X_MSB = 31;
  localparam int RD_X_LSB = 16;
  localparam int RD_Y_MSB = 15;
  localparam int RD_Y_LSB = 0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } grid_state_t;

  // Full 16-bit fields are checked so wrapped coordinates (e.g. -1) count as walls
  function automatic logic coord_in_range(input logic [15:0] x, input logic [15:0] y);
    return (x[15:X_BITS] == '0) && (y < 16'(GRID_SIZE_Y));
  endfunction

  function automatic logic [IDX_W-1:0] cell_index(input logic [15:0] x, input logic [15:0] y);
    return {y[Y_BITS-1:0], x[X_BITS-1:0]};
  endfunction

endpackage

// File: rtl/grid_ram.sv
// Cell storage: one synchronous write port, one asynchronous read port for the
// game controller and one registered read port for the display.
module grid_ram #(
  parameter int DEPTH = 768,
  parameter int AW    = 10,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_ard_addr,
  output logic [DW-1:0] o_ard_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  // Write port; a read of the same cell on this edge still sees the old value
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered display read, held between requests
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_ard_data = r_mem[i_ard_addr];
  assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/rect_grid_memory.sv
// Play-field cell store: clears the field after reset or on request, applies
// controller rectangle writes, answers controller reads combinationally
// (walls read as ROCK) and serves a one-cycle pipelined display read port.
module rect_grid_memory
  import rect_grid_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WR_W-1:0]   rect_write,
  input  logic [RD_W-1:0]   rect_read_addr,
  output logic [CELL_W-1:0] rect_read_data,
  input  logic              clear_req,
  output logic              busy,
  input  logic              disp_valid,
  input  logic [X_BITS-1:0] disp_x,
  input  logic [Y_BITS-1:0] disp_y,
  output logic [CELL_W-1:0] disp_data,
  output logic              disp_data_valid,
  output logic              oob_flag
);

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  logic [15:0]      w_wr_x;
  logic [15:0]      w_wr_y;
  logic [15:0]      w_rd_x;
  logic [15:0]      w_rd_y;
  cell_t            w_wr_func;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_disp_ok;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_disp_idx;

  grid_state_t      r_state;
  grid_state_t      w_state_next;
  logic [IDX_W-1:0] r_count;
  logic [IDX_W-1:0] w_count_next;

  logic             w_ram_we;
  logic [IDX_W-1:0] w_ram_waddr;
  cell_t            w_ram_wdata;
  cell_t            w_ram_adata;
  cell_t            w_ram_qdata;

  logic             r_oob;
  logic             r_disp_valid;
  logic             r_disp_rock;

  assign w_wr_x    = rect_write[WR_X_MSB:WR_X_LSB];
  assign w_wr_y    = rect_write[WR_Y_MSB:WR_Y_LSB];
  assign w_wr_func = rect_write[WR_F_MSB:WR_F_LSB];
  assign w_rd_x    = rect_read_addr[RD_X_MSB:RD_X_LSB];
  assign w_rd_y    = rect_read_addr[RD_Y_MSB:RD_Y_LSB];

  assign w_wr_ok    = coord_in_range(w_wr_x, w_wr_y);
  assign w_rd_ok    = coord_in_range(w_rd_x, w_rd_y);
  assign w_wr_idx   = cell_index(w_wr_x, w_wr_y);
  assign w_rd_idx   = cell_index(w_rd_x, w_rd_y);
  assign w_disp_ok  = disp_y < Y_BITS'(GRID_SIZE_Y);
  assign w_disp_idx = {disp_y, disp_x};

  // FSM state and clear counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // Next state, clear sweep and write-port steering
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_ram_we     = 1'b0;
    w_ram_waddr  = r_count;
    w_ram_wdata  = CELL_NULL;
    case (r_state)
      ST_CLEAR: begin
        w_ram_we = 1'b1;
        if (clear_req) begin
          w_count_next = '0;
        end else if (r_count == LAST_IDX) begin
          w_state_next = ST_RUN;
        end else begin
          w_count_next = r_count + IDX_ONE;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          // Clear wins over a same-cycle write
          w_state_next = ST_CLEAR;
          w_count_next = '0;
        end else if (w_wr_ok) begin
          w_ram_we    = 1'b1;
          w_ram_waddr = w_wr_idx;
          w_ram_wdata = w_wr_func;
        end
      end
      default: begin
        w_state_next = ST_CLEAR;
        w_count_next = '0;
      end
    endcase
  end

  // Sticky out-of-range write flag, cleared by a clear request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_oob <= 1'b0;
    end else if (clear_req) begin
      r_oob <= 1'b0;
    end else if (r_state == ST_RUN && !w_wr_ok) begin
      r_oob <= 1'b1;
    end
  end

  // Display pipeline: valid and wall-substitution travel alongside the RAM read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_disp_valid <= 1'b0;
      r_disp_rock  <= 1'b0;
    end else begin
      r_disp_valid <= disp_valid;
      if (disp_valid) begin
        r_disp_rock <= !w_disp_ok;
      end
    end
  end

  grid_ram #(
    .DEPTH (CELL_NUM),
    .AW    (IDX_W),
    .DW    (CELL_W)
  ) u_grid_ram (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_ram_we),
    .i_wr_addr  (w_ram_waddr),
    .i_wr_data  (w_ram_wdata),
    .i_ard_addr (w_rd_idx),
    .o_ard_data (w_ram_adata),
    .i_rd_en    (disp_valid),
    .i_rd_addr  (w_disp_idx),
    .o_rd_data  (w_ram_qdata)
  );

  assign busy            = (r_state == ST_CLEAR);
  assign rect_read_data  = (r_state == ST_CLEAR) ? CELL_NULL :
                           (w_rd_ok ? w_ram_adata : CELL_ROCK);
  assign disp_data       = r_disp_rock ? CELL_ROCK : w_ram_qdata;
  assign disp_data_valid = r_disp_valid;
  assign oob_flag        = r_oob;

endmodule

// File: tb/tb_rect_grid_memory.sv
// Directed bench for rect_grid_memory: clear timing, writes, wall reads,
// same-cycle read/write ordering, display pipeline and clear/reset restarts.
module tb_rect_grid_memory;

  logic        clk;
  logic        rst_n;
  logic [35:0] rect_write;
  logic [31:0] rect_read_addr;
  logic [3:0]  rect_read_data;
  logic        clear_req;
  logic        busy;
  logic        disp_valid;
  logic [4:0]  disp_x;
  logic [4:0]  disp_y;
  logic [3:0]  disp_data;
  logic        disp_data_valid;
  logic        oob_flag;

  int n_total = 0;
  int n_bad   = 0;

  rect_grid_memory dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rect_write      (rect_write),
    .rect_read_addr  (rect_read_addr),
    .rect_read_data  (rect_read_data),
    .clear_req       (clear_req),
    .busy            (busy),
    .disp_valid      (disp_valid),
    .disp_x          (disp_x),
    .disp_y          (disp_y),
    .disp_data       (disp_data),
    .disp_data_valid (disp_data_valid),
    .oob_flag        (oob_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic wr(input logic [15:0] x, input logic [15:0] y, input logic [3:0] f);
    rect_write = {x, y, f};
  endtask

  // Idle traffic rewrites NULL into (0,0), which is never used for data
  task automatic idle_wr();
    rect_write = {16'd0, 16'd0, 4'b0000};
  endtask

  task automatic rd(input logic [15:0] x, input logic [15:0] y);
    rect_read_addr = {x, y};
    #1;
  endtask

  // Counts clock edges until busy drops; bounded so a stuck clear still ends
  task automatic busy_len(input string tag);
    int cnt;
    cnt = 0;
    while (busy && cnt < 3000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    idle_wr();
    chk(tag, cnt, 768);
  endtask

  task automatic scan_nonnull(input string tag);
    int nz;
    nz = 0;
    for (int y = 0; y < 24; y++) begin
      for (int x = 0; x < 32; x++) begin
        rd(16'(x), 16'(y));
        if (rect_read_data !== 4'b0000) nz++;
      end
    end
    chk(tag, nz, 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    clear_req      = 1'b0;
    disp_valid     = 1'b0;
    disp_x         = '0;
    disp_y         = '0;
    rect_read_addr = '0;
    idle_wr();

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_dvalid", disp_data_valid, 0);
    chk("rst_ddata", disp_data, 0);
    chk("rst_oob", oob_flag, 0);
    rst_n = 1'b1;
    busy_len("init_clear_len");
    @(negedge clk);

    rd(16'd3, 16'd4);
    chk("read_3_4_null", rect_read_data, 4'b0000);
    chk("dvalid_idle", disp_data_valid, 0);

    // Write SNAKE at (5,7), read back next cycle
    wr(16'd5, 16'd7, 4'b0001);
    @(negedge clk);
    idle_wr();
    rd(16'd5, 16'd7);
    chk("read_5_7_snake", rect_read_data, 4'b0001);

    // Display request (5,7), data one cycle later
    disp_valid = 1'b1;
    disp_x = 5'd5;
    disp_y = 5'd7;
    @(negedge clk);
    disp_valid = 1'b0;
    chk("disp_5_7_data", disp_data, 4'b0001);
    chk("disp_5_7_valid", disp_data_valid, 1);
    @(negedge clk);
    chk("disp_valid_drop", disp_data_valid, 0);

    // Wall reads
    rd(16'hFFFF, 16'd15);
    chk("read_wrap_x_rock", rect_read_data, 4'b0010);
    rd(16'd0, 16'd24);
    chk("read_y24_rock", rect_read_data, 4'b0010);
    rd(16'd31, 16'd23);
    chk("read_corner_null", rect_read_data, 4'b0000);

    // Out-of-range write aliasing onto (0,0) must be dropped
    chk("oob_before", oob_flag, 0);
    wr(16'd32, 16'd0, 4'b0001);
    @(negedge clk);
    idle_wr();
    chk("oob_set", oob_flag, 1);
    rd(16'd0, 16'd0);
    chk("cell_0_0_null", rect_read_data, 4'b0000);
    @(negedge clk);
    chk("oob_sticky", oob_flag, 1);

    // Display row out of range returns ROCK
    disp_valid = 1'b1;
    disp_x = 5'd0;
    disp_y = 5'd24;
    @(negedge clk);
    disp_valid = 1'b0;
    chk("disp_y24_rock", disp_data, 4'b0010);

    // Same-cycle write and read returns the old value
    rect_read_addr = {16'd10, 16'd10};
    wr(16'd10, 16'd10, 4'b0100);
    #1;
    chk("rw_same_old", rect_read_data, 4'b0000);
    @(negedge clk);
    idle_wr();
    #1;
    chk("rw_same_new", rect_read_data, 4'b0100);

    // Display sees old value on a colliding write, then back-to-back new value
    wr(16'd12, 16'd3, 4'hA);
    disp_valid = 1'b1;
    disp_x = 5'd12;
    disp_y = 5'd3;
    @(negedge clk);
    idle_wr();
    chk("disp_rw_old", disp_data, 4'h0);
    @(negedge clk);
    disp_valid = 1'b0;
    chk("disp_rw_new", disp_data, 4'hA);

    // Fill 20 cells in row 2
    for (int i = 0; i < 20; i++) begin
      wr(16'(i + 1), 16'd2, 4'((i % 15) + 1));
      @(negedge clk);
    end
    idle_wr();
    rd(16'd20, 16'd2);
    chk("fill_20_2", rect_read_data, 4'd5);

    // Clear request with a same-cycle write: clear wins
    clear_req = 1'b1;
    wr(16'd21, 16'd2, 4'hF);
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    wr(16'd3, 16'd2, 4'hF);
    chk("clr_busy", busy, 1);
    chk("clr_oob_cleared", oob_flag, 0);
    rd(16'd5, 16'd7);
    chk("clr_read_null", rect_read_data, 4'b0000);
    busy_len("req_clear_len");
    @(negedge clk);
    scan_nonnull("after_clear_nonnull");

    // clear_req mid-clear restarts the sweep
    wr(16'd1, 16'd1, 4'b0001);
    @(negedge clk);
    idle_wr();
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (99) @(negedge clk);
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    busy_len("restart_req_len");
    @(negedge clk);

    // Reset mid-clear (count 400) restarts the sweep
    wr(16'd1, 16'd1, 4'b0001);
    @(negedge clk);
    idle_wr();
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (400) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 1);
    rst_n = 1'b1;
    busy_len("rst_mid_len");
    @(negedge clk);
    rd(16'd1, 16'd1);
    chk("rst_mid_cell_null", rect_read_data, 4'b0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rect_grid_memory.md
# rect_grid_memory

Grid cell store and responder for the rectangle write/read interface driven by the snake game controller. Holds one 4-bit cell code per cell of the 32x24 play field. Applies the controller's rect_write commands and answers its rect_read address with the cell code, combinationally, in the same cycle. Also serves a second, pipelined read port for the VGA renderer and clears the whole field at reset or on request.

## Interface
- GRID_SIZE_X, 32: cells per row; power of two.
- GRID_SIZE_Y, 24: rows.
- CELL_W, 4: cell code width.
- clk  in  1  system clock.
- rst_n  in  1  one clock; reset is synchronous and active-low.
- rect_write  in  36  {x[35:20], y[19:4], func[3:0]}; applied every cycle unless ignored.
- rect_read_addr  in  32  {x[31:16], y[15:0]}; controller read address.
- rect_read_data  out  4  cell code at rect_read_addr; combinational.
- clear_req  in  1  one-cycle pulse; starts a full-field clear.
- busy  out  1  high while a clear is in progress.
- disp_valid  in  1  display read request.
- disp_x  in  5  display column.
- disp_y  in  5  display row.
- disp_data  out  4  cell code for the request made one cycle earlier.
- disp_data_valid  out  1  disp_valid delayed by one cycle.
- oob_flag  out  1  sticky; set when a write lands out of range; cleared by reset or clear_req.

## Operation
- Cell codes: NULL 4'b0000, SNAKE 4'b0001, ROCK 4'b0010, SNACK 4'b0100. Any other code is stored as given.
- Index is {y[4:0], x[4:0]}, 10 bits, covering 0..767.
- A coordinate is in range when x[15:5]==0, y[15:5]==0 and y[4:0]<GRID_SIZE_Y. Widths are the full 16-bit fields.
- State machine, two states:
  - CLEAR: a 10-bit counter writes NULL at counter index, one cell per cycle, from 0 to 767. After index 767 the FSM goes to RUN. busy=1 throughout. rect_write is ignored. rect_read_data=NULL. The display port reads memory normally.
  - RUN: an in-range rect_write writes func at its index on every clk edge. Repeated identical writes are harmless. An out-of-range write is dropped and sets oob_flag. clear_req enters CLEAR with counter=0.
- rect_read_data in RUN:
  - In range: the stored code.
  - Out of range, including wrapped coordinates such as 16'hFFFF: ROCK. The controller then detects a wall hit as game over.
- Display port: disp_data is registered from the memory at {disp_y, disp_x}. An out-of-range disp_y returns ROCK.

## Timing
- Reset values: FSM=CLEAR, counter=0, busy=1, disp_data=0, disp_data_valid=0, oob_flag=0.
- The clear lasts exactly 768 cycles after rst_n is released. busy falls on the edge after index 767 is written.
- rst_n low at any point, including mid-clear, restarts the clear from 0.
- clear_req during CLEAR restarts the counter at 0.
- rect_read_data has zero latency from rect_read_addr. A write committed at edge N is visible after edge N.
- Write and read of the same cell in the same cycle: the read returns the old value. The same applies to the display port.
- Display latency is 1 cycle, fully pipelined at one request per cycle.
- clear_req and a write in the same RUN cycle: the clear wins and the write is dropped.

## Structure
- Package rect_grid_pkg: GRID_SIZE_X/Y, cell codes NULL/SNAKE/ROCK/SNACK, rect_write and rect_read field bit positions, FSM state encoding. The game controller imports the same package.
- Sub-module grid_ram: 768x4 distributed RAM with one synchronous write port, one asynchronous read port and one registered read port.
- rect_grid_memory contains the FSM, clear counter, range checks, ROCK substitution and oob_flag.

## Test plan
- rst_n low for 2 cycles, then high -> busy stays high for exactly 768 cycles. Afterwards, a read of {3,4} returns 4'b0000 and disp_data_valid=0.
- rect_write={x=5, y=7, SNAKE} for one cycle -> next cycle, rect_read_addr={5,7} gives 4'b0001. A display request (5,7) then gives disp_data=1 with disp_data_valid=1 one cycle later.
- rect_read_addr={16'hFFFF, 16'd15} -> ROCK the same cycle. rect_write={x=32, y=0, SNAKE} -> dropped and oob_flag=1. Cell {0,0} stays NULL.
- Cell (10,10)=NULL, then a same-cycle write of SNACK and read at (10,10) -> 4'b0000 that cycle, 4'b0100 the next.
- Fill 20 cells, then pulse clear_req -> busy high for 768 cycles. Writes during busy are ignored and all cells read NULL afterwards. rst_n low at count 400 -> busy remains high for 768 cycles after release.
